// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART: parity modes, TX/RX FSM states
// and the parity helper used by both directions.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Data is zero-extended to 9 bits; padding does not change the XOR.
    function automatic logic parity_bit(input logic [8:0] d, input int par);
        return (^d) ^ (par == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: ticks once every CLK_DIV cycles; a half-load makes the
// first tick land CLK_DIV/2 cycles later (used to centre RX sampling).
module uart_baud_cnt #(
    parameter int CLK_DIV = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_half_load,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV - CLK_DIV / 2);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_half_load) begin
            r_cnt <= HALF;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART with valid/ready on both sides, RX synchroniser,
// start-glitch rejection and parity/framing/overrun reporting.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 87,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 tx,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 tx_done,
    input  logic                 rx,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 rx_overrun
);

    if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_cfg: CLK_DIV must be 4..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_cfg: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam bit         HAS_PAR   = (PARITY != PAR_NONE);

    // ---------------- TX ----------------
    tx_state_t            r_tx_state, w_tx_next;
    logic                 w_tx_tick, w_tx_go, w_tx;
    logic [3:0]           r_tx_cnt;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par, r_tx_done;

    uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_tx_baud (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_tx_state == TX_IDLE),
        .i_half_load(1'b0),
        .o_tick     (w_tx_tick)
    );

    assign i_ready = (r_tx_state == TX_IDLE);
    assign w_tx_go = i_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx      = 1'b1;
        case (r_tx_state)
            TX_IDLE:   if (w_tx_go) w_tx_next = TX_START;
            TX_START: begin
                w_tx = 1'b0;
                if (w_tx_tick) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                w_tx = r_tx_shift[0];
                if (w_tx_tick && r_tx_cnt == LAST_BIT)
                    w_tx_next = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                w_tx = r_tx_par;
                if (w_tx_tick) w_tx_next = TX_STOP;
            end
            TX_STOP:   if (w_tx_tick && r_tx_cnt == LAST_STOP) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    assign tx      = w_tx;
    assign tx_done = r_tx_done;

    // r_tx_cnt counts data bits, then is reused to count stop bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= (r_tx_state == TX_STOP) && w_tx_tick && (r_tx_cnt == LAST_STOP);
            if (w_tx_go) begin
                r_tx_shift <= i_data;
                r_tx_par   <= parity_bit(9'(i_data), PARITY);
                r_tx_cnt   <= '0;
            end else if (w_tx_tick) begin
                case (r_tx_state)
                    TX_DATA: begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_cnt   <= (r_tx_cnt == LAST_BIT) ? 4'd0 : r_tx_cnt + 4'd1;
                    end
                    TX_STOP: r_tx_cnt <= r_tx_cnt + 4'd1;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t            r_rx_state, w_rx_next;
    logic                 r_rx_meta, r_rx_s;
    logic                 w_rx_tick, w_rx_done;
    logic [3:0]           r_rx_cnt;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_err;
    logic                 r_o_valid, r_o_perr, r_o_ferr, r_overrun;
    logic [DATA_BITS-1:0] r_o_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Half-load is held through IDLE so the start-bit check lands mid-bit.
    uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_rx_baud (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (1'b0),
        .i_half_load(r_rx_state == RX_IDLE),
        .o_tick     (w_rx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:   if (!r_rx_s) w_rx_next = RX_START;
            RX_START:  if (w_rx_tick) w_rx_next = r_rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_rx_tick && r_rx_cnt == LAST_BIT)
                           w_rx_next = HAS_PAR ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_tick) w_rx_next = RX_STOP;
            RX_STOP:   if (w_rx_tick) w_rx_next = RX_IDLE;
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    assign w_rx_done = (r_rx_state == RX_STOP) && w_rx_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_cnt     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_err <= 1'b0;
        end else if (w_rx_tick) begin
            case (r_rx_state)
                RX_START:  r_rx_cnt <= '0;
                RX_DATA: begin
                    r_rx_shift <= {r_rx_s, r_rx_shift[DATA_BITS-1:1]};
                    r_rx_cnt   <= r_rx_cnt + 4'd1;
                end
                RX_PARITY: r_rx_par_err <= r_rx_s ^ parity_bit(9'(r_rx_shift), PARITY);
                default: ;
            endcase
        end
    end

    // Holding register: a completed frame is dropped if the old one is unconsumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_perr  <= 1'b0;
            r_o_ferr  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_rx_done) begin
                if (!r_o_valid || o_ready) begin
                    r_o_valid <= 1'b1;
                    r_o_data  <= r_rx_shift;
                    r_o_perr  <= r_rx_par_err;
                    r_o_ferr  <= !r_rx_s;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_o_valid && o_ready) begin
                r_o_valid <= 1'b0;
            end
        end
    end

    assign o_valid      = r_o_valid;
    assign o_data       = r_o_data;
    assign o_parity_err = r_o_perr;
    assign o_frame_err  = r_o_ferr;
    assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: default 8N1 instance plus parity, 2-stop and
// 7-bit variants (the latter two looped back tx->rx).
module tb_uart_cfg;
    import uart_pkg::*;

    localparam int CD0 = 87;
    localparam int CDV = 11;

    logic clk = 1'b0;
    logic r_rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] r_iv = '0;
    logic [8:0] r_id [5];
    logic [4:0] r_or = 5'h1F;
    logic [4:0] r_rx = 5'h1F;
    logic       r_loop0 = 1'b0;

    wire  [4:0] w_tx, w_ir, w_done, w_ov, w_pe, w_fe, w_ovr;
    wire  [7:0] w_od0, w_od1, w_od2, w_od3;
    wire  [6:0] w_od4;
    wire        w_rx0;
    logic [8:0] w_od [5];

    assign w_rx0 = r_loop0 ? w_tx[0] : r_rx[0];
    assign w_od[0] = {1'b0, w_od0};
    assign w_od[1] = {1'b0, w_od1};
    assign w_od[2] = {1'b0, w_od2};
    assign w_od[3] = {1'b0, w_od3};
    assign w_od[4] = {2'b0, w_od4};

    uart_cfg #(.CLK_DIV(CD0)) dut0 (
        .clk(clk), .rst(r_rst), .tx(w_tx[0]), .i_valid(r_iv[0]), .i_ready(w_ir[0]),
        .i_data(r_id[0][7:0]), .tx_done(w_done[0]), .rx(w_rx0), .o_valid(w_ov[0]),
        .o_ready(r_or[0]), .o_data(w_od0), .o_parity_err(w_pe[0]), .o_frame_err(w_fe[0]),
        .rx_overrun(w_ovr[0]));
    uart_cfg #(.CLK_DIV(CDV), .PARITY(2)) dut1 (
        .clk(clk), .rst(r_rst), .tx(w_tx[1]), .i_valid(r_iv[1]), .i_ready(w_ir[1]),
        .i_data(r_id[1][7:0]), .tx_done(w_done[1]), .rx(r_rx[1]), .o_valid(w_ov[1]),
        .o_ready(r_or[1]), .o_data(w_od1), .o_parity_err(w_pe[1]), .o_frame_err(w_fe[1]),
        .rx_overrun(w_ovr[1]));
    uart_cfg #(.CLK_DIV(CDV), .PARITY(1)) dut2 (
        .clk(clk), .rst(r_rst), .tx(w_tx[2]), .i_valid(r_iv[2]), .i_ready(w_ir[2]),
        .i_data(r_id[2][7:0]), .tx_done(w_done[2]), .rx(r_rx[2]), .o_valid(w_ov[2]),
        .o_ready(r_or[2]), .o_data(w_od2), .o_parity_err(w_pe[2]), .o_frame_err(w_fe[2]),
        .rx_overrun(w_ovr[2]));
    uart_cfg #(.CLK_DIV(CDV), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(r_rst), .tx(w_tx[3]), .i_valid(r_iv[3]), .i_ready(w_ir[3]),
        .i_data(r_id[3][7:0]), .tx_done(w_done[3]), .rx(w_tx[3]), .o_valid(w_ov[3]),
        .o_ready(r_or[3]), .o_data(w_od3), .o_parity_err(w_pe[3]), .o_frame_err(w_fe[3]),
        .rx_overrun(w_ovr[3]));
    uart_cfg #(.CLK_DIV(CDV), .DATA_BITS(7)) dut4 (
        .clk(clk), .rst(r_rst), .tx(w_tx[4]), .i_valid(r_iv[4]), .i_ready(w_ir[4]),
        .i_data(r_id[4][6:0]), .tx_done(w_done[4]), .rx(w_tx[4]), .o_valid(w_ov[4]),
        .o_ready(r_or[4]), .o_data(w_od4), .o_parity_err(w_pe[4]), .o_frame_err(w_fe[4]),
        .rx_overrun(w_ovr[4]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / capture ----------------
    logic [9:0] exp_q [$];   // {frame_err, parity_err, data[7:0]} for dut0
    int         ovr_cnt0 = 0;
    int         cap_cnt [5] = '{default: 0};
    logic [8:0] cap_data [5];
    logic       cap_pe [5];
    logic       cap_fe [5];

    always @(negedge clk) begin
        if (w_ovr[0]) ovr_cnt0++;
        if (w_ov[0] && r_or[0]) begin
            if (exp_q.size() == 0) begin
                chk("rx0_unexpected_frame", 32'(w_ov[0]), 32'd0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("rx0_frame", 32'({w_fe[0], w_pe[0], w_od0}), 32'(e));
            end
        end
        for (int i = 1; i < 5; i++) begin
            if (w_ov[i] && r_or[i]) begin
                cap_cnt[i]++;
                cap_data[i] = w_od[i];
                cap_pe[i]   = w_pe[i];
                cap_fe[i]   = w_fe[i];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int sel, input logic [8:0] d);
        int n = 0;
        while (!w_ir[sel] && n < 2000) begin
            step(1);
            n++;
        end
        if (!w_ir[sel]) chk("send_ready_timeout", 32'(w_ir[sel]), 32'd1);
        r_iv[sel] = 1'b1;
        r_id[sel] = d;
        step(1);
        r_iv[sel] = 1'b0;
    endtask

    task automatic drive_frame(input int sel, input logic [8:0] d, input int nbits,
                               input bit par_en, input logic par, input logic stop,
                               input int cd);
        r_rx[sel] = 1'b0;
        step(cd);
        for (int i = 0; i < nbits; i++) begin
            r_rx[sel] = d[i];
            step(cd);
        end
        if (par_en) begin
            r_rx[sel] = par;
            step(cd);
        end
        r_rx[sel] = stop;
        step(cd);
        r_rx[sel] = 1'b1;
    endtask

    // Called right after send(): region 1 is the first cycle after the transfer.
    task automatic wait_done(input int sel, input int exp_cycle, input string tag);
        int first = 0;
        for (int r = 1; r <= exp_cycle + 40; r++) begin
            if (w_done[sel] && first == 0) first = r;
            step(1);
        end
        chk(tag, first, exp_cycle);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] exp_ab;
        int first, n_done, rdy_hi, ovr0;
        for (int i = 0; i < 5; i++) r_id[i] = '0;
        exp_ab = 10'b1_1010_1011_0;   // stop, 0xAB MSB..LSB, start

        // reset state
        step(3);
        chk("rst_tx_idle_high", 32'(w_tx), 32'h1F);
        chk("rst_o_valid", 32'(w_ov), 32'h0);
        chk("rst_o_data0", 32'(w_od0), 32'h0);
        chk("rst_tx_done", 32'(w_done), 32'h0);
        chk("rst_overrun", 32'(w_ovr), 32'h0);
        r_rst = 1'b0;
        step(1);
        chk("rst_i_ready", 32'(w_ir), 32'h1F);

        // TX 0xAB, 8N1
        send(0, 9'h0AB);
        first = 0; n_done = 0; rdy_hi = 0;
        for (int r = 1; r <= 900; r++) begin
            if (r >= 44 && (r - 44) % CD0 == 0 && (r - 44) / CD0 < 10)
                chk($sformatf("tx_ab_bit%0d", (r - 44) / CD0), 32'(w_tx[0]),
                    32'(exp_ab[(r - 44) / CD0]));
            if (w_done[0]) begin
                n_done++;
                if (first == 0) first = r;
            end
            if (r < 871 && w_ir[0]) rdy_hi++;
            step(1);
        end
        chk("tx_ab_done_cycle", first, 871);
        chk("tx_ab_done_count", n_done, 1);
        chk("tx_ab_ready_low", rdy_hi, 0);

        // RX two back-to-back frames
        exp_q.push_back({2'b00, 8'h3F});
        exp_q.push_back({2'b00, 8'hA5});
        drive_frame(0, 9'h03F, 8, 1'b0, 1'b0, 1'b1, CD0);
        drive_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, CD0);
        step(100);
        chk("rx_b2b_drained", exp_q.size(), 0);

        // start-bit glitch
        r_rx[0] = 1'b0;
        step(20);
        r_rx[0] = 1'b1;
        step(100);
        chk("glitch_rx_idle", 32'(dut0.r_rx_state), 32'(RX_IDLE));
        chk("glitch_no_valid", 32'(w_ov[0]), 32'd0);

        // framing error
        exp_q.push_back({2'b10, 8'h55});
        drive_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, CD0);
        step(200);
        chk("rx_fe_drained", exp_q.size(), 0);

        // overrun
        r_or[0] = 1'b0;
        ovr0 = ovr_cnt0;
        exp_q.push_back({2'b00, 8'h11});
        drive_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, CD0);
        drive_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1, CD0);
        step(100);
        chk("ovr_valid_held", 32'(w_ov[0]), 32'd1);
        chk("ovr_data_kept", 32'(w_od0), 32'h11);
        chk("ovr_pulse_count", ovr_cnt0 - ovr0, 1);
        r_or[0] = 1'b1;
        step(1);
        chk("ovr_valid_cleared", 32'(w_ov[0]), 32'd0);
        chk("ovr_drained", exp_q.size(), 0);

        // reset mid-TX (data bit 3) and mid-RX, with a frame held
        r_or[0] = 1'b0;
        drive_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, CD0);
        step(100);
        chk("held_valid", 32'(w_ov[0]), 32'd1);
        chk("held_data", 32'(w_od0), 32'h5A);
        r_rx[0] = 1'b0;
        send(0, 9'h0AB);
        step(388);
        chk("pre_rst_tx_data", 32'(dut0.r_tx_state), 32'(TX_DATA));
        r_rst = 1'b1;
        r_rx[0] = 1'b1;
        step(1);
        chk("mid_rst_tx_high", 32'(w_tx[0]), 32'd1);
        chk("mid_rst_o_valid", 32'(w_ov[0]), 32'd0);
        chk("mid_rst_o_data", 32'(w_od0), 32'd0);
        chk("mid_rst_rx_idle", 32'(dut0.r_rx_state), 32'(RX_IDLE));
        r_rst = 1'b0;
        step(1);
        chk("post_rst_i_ready", 32'(w_ir[0]), 32'd1);
        r_or[0] = 1'b1;
        n_done = 0;
        for (int r = 0; r < 1000; r++) begin
            if (w_done[0]) n_done++;
            step(1);
        end
        chk("post_rst_no_done", n_done, 0);

        // loopback round-trip after reset
        r_loop0 = 1'b1;
        exp_q.push_back({2'b00, 8'hC3});
        send(0, 9'h0C3);
        wait_done(0, 871, "rt_c3_done_cycle");
        step(20);
        chk("rt_c3_drained", exp_q.size(), 0);
        r_loop0 = 1'b0;

        // parity on TX: even -> 0, odd -> 1 for 0x3F (sample mid parity bit)
        send(1, 9'h03F);
        step(104);
        chk("tx_even_par_bit", 32'(w_tx[1]), 32'd0);
        send(2, 9'h03F);
        step(104);
        chk("tx_odd_par_bit", 32'(w_tx[2]), 32'd1);
        step(30);

        // parity on RX
        drive_frame(1, 9'h03F, 8, 1'b1, 1'b1, 1'b1, CDV);
        step(20);
        chk("rx_even_bad_cnt", cap_cnt[1], 1);
        chk("rx_even_bad_data", 32'(cap_data[1]), 32'h3F);
        chk("rx_even_bad_perr", 32'(cap_pe[1]), 32'd1);
        chk("rx_even_bad_ferr", 32'(cap_fe[1]), 32'd0);
        drive_frame(1, 9'h03F, 8, 1'b1, 1'b0, 1'b1, CDV);
        step(20);
        chk("rx_even_good_perr", 32'(cap_pe[1]), 32'd0);
        drive_frame(2, 9'h03F, 8, 1'b1, 1'b1, 1'b1, CDV);
        step(20);
        chk("rx_odd_good_cnt", cap_cnt[2], 1);
        chk("rx_odd_good_perr", 32'(cap_pe[2]), 32'd0);

        // variants: 2 stop bits, 7 data bits, looped back
        send(3, 9'h0C3);
        wait_done(3, 122, "s2_done_cycle");
        chk("s2_rx_cnt", cap_cnt[3], 1);
        chk("s2_rx_data", 32'(cap_data[3]), 32'hC3);
        chk("s2_rx_flags", 32'({cap_fe[3], cap_pe[3]}), 32'd0);
        send(4, 9'h0C3);
        wait_done(4, 100, "d7_done_cycle");
        chk("d7_rx_cnt", cap_cnt[4], 1);
        chk("d7_rx_data", 32'(cap_data[4]), 32'h43);
        chk("d7_rx_flags", 32'({cap_fe[4], cap_pe[4]}), 32'd0);

        chk("final_rx0_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
Parametrised full-duplex UART. It replaces the fixed 8N1 uart and adds:
- configurable data width, parity and stop-bit count
- valid/ready handshakes on both the TX and RX sides
- an RX input synchroniser, start-bit glitch rejection and parity/framing/overrun error reporting

It sits between the CPU's memory-mapped I/O register logic and the board serial pins.

Parameters:
- CLK_DIV, 87: clock cycles per bit (10 MHz / 115200, ceil). Legal range 4..65535.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: one clock; synchronous, active-high
- tx  out  1  serial output, idle high
- i_valid  in  1  TX byte offered
- i_ready  out  1  TX can accept; high only while the TX FSM is IDLE
- i_data  in  DATA_BITS  TX data
- tx_done  out  1  one-cycle pulse when a frame's last stop bit completes
- rx  in  1  serial input, asynchronous
- o_valid  out  1  RX holding register full
- o_ready  in  1  consumer takes RX data
- o_data  out  DATA_BITS  received data
- o_parity_err  out  1  parity mismatch; qualified by o_valid
- o_frame_err  out  1  first stop bit sampled low; qualified by o_valid
- rx_overrun  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
Reset
- While rst is high, at the next edge: tx=1, tx_done=0, o_valid=0, o_data=0, both error flags 0, rx_overrun=0.
- Both FSMs go to IDLE and all counters clear.
- Applies mid-frame too: a partial TX frame is aborted with tx high; a partial RX frame is discarded.
- i_ready=1 from the first cycle after rst deasserts.

Baud counter
- Counts 0..CLK_DIV-1; width $clog2(CLK_DIV).
- A bit period is exactly CLK_DIV cycles.

TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
- Transfer occurs when i_valid && i_ready; i_data is latched at that edge.
- tx=0 from the next cycle for CLK_DIV cycles.
- DATA_BITS data bits, LSB first.
- Parity bit, if PARITY!=0: even = XOR of data; odd = its inverse.
- Then STOP_BITS*CLK_DIV cycles of tx=1.
- On the cycle after the last stop cycle: tx_done=1 and the FSM is in IDLE (i_ready=1).
- A transfer in that same cycle starts the next start bit on the following cycle: back-to-back frames with no idle gap.
- i_valid while not ready is ignored; the data is not queued.

RX synchroniser
- 2-flop synchroniser to rx_s. Latency of 2 cycles is included in all sampling.

RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
- IDLE: move to START when rx_s==0.
- START: wait CLK_DIV/2 (floor) cycles, then sample. If 1, it was a glitch: back to IDLE, nothing reported. If 0, go to DATA.
- DATA: sample every CLK_DIV cycles, DATA_BITS samples, shifted in LSB first.
- PARITY: one sample, compared against the computed parity.
- STOP: sample the first stop bit only; frame_err = !sample. The frame completes at this sample and the FSM returns to IDLE the same cycle, so it can re-arm during the stop bit(s).
- STOP_BITS affects TX only.

RX holding register
- On frame completion with o_valid=0 (or o_valid && o_ready in the same cycle): load data and flags; o_valid=1 next cycle.
- On completion while o_valid && !o_ready: the new frame is dropped, the old data is retained, and rx_overrun pulses for 1 cycle.
- o_valid && o_ready with no new frame: o_valid=0 next cycle.
- A frame with frame_err is still delivered, with the flag set.
- The unused parity flag reads 0 when PARITY=0.

Elaboration checks
- Illegal parameter values stop elaboration with $error.

Decomposition:
- uart_pkg holds the parity encodings (PAR_NONE/PAR_ODD/PAR_EVEN) and the TX/RX state encodings.
- One sub-module, uart_baud_cnt (CLK_DIV; inputs clear/half-load; output tick), instantiated once for TX and once for RX.
- Top-level uart_cfg holds both FSMs, the synchroniser and the holding register.

Test Plan:
- Defaults, send 0xAB:
  - tx = 0, then 1,1,0,1,0,1,0,1, then 1, each bit 87 cycles.
  - tx_done pulses 871 cycles after the transfer; i_ready is low throughout.
- PARITY=2 and PARITY=1, send 0x3F:
  - parity bit 0 (even) / 1 (odd).
  - Drive the RX side with a parity bit of 1 under even: o_data=0x3F, o_parity_err=1.
- Defaults, drive rx with 0x3F (8N1, 87-cycle bits), o_ready=1:
  - o_valid pulses with o_data=0x3F, both error flags 0.
  - A second frame immediately after is also received correctly.
- rx low for 20 cycles then high:
  - no o_valid, state back in IDLE.
  - Frame 0x55 with stop bit driven 0: o_frame_err=1, o_data=0x55.
- o_ready=0, send 0x11 then 0x22:
  - o_data stays 0x11, rx_overrun pulses once.
  - o_ready=1 then clears o_valid.
- rst asserted mid-TX (data bit 3) and mid-RX:
  - next cycle tx=1, o_valid=0, i_ready=1 after release.
  - A subsequent 0xC3 round-trips correctly, with STOP_BITS=2 and DATA_BITS=7 variants.
